multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath, replacing single-cycle control. It steps each instruction through IF/ID/EX/MEM/WB, driving the existing datapath muxes and enables one phase at a time. A shared unified memory port with a ready handshake stretches memory phases; a watchdog traps a hung memory. Instruction set: add, sub, addu, subu, slt, sll, ori, slti, lui, lw, sw, beq, bne, j.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready in any memory state before trap (1..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26], valid from ID onward
func  in  6  IR[5:0]
zero  in  1  datapath comparator, 1 when rs==rt
mem_ready  in  1  memory completes the current access this cycle
pc_we  out  1  PC write enable
ir_we  out  1  IR write enable
mem_rd / mem_wr  out  1 / 1  memory strobes, held until mem_ready
iord  out  1  0 = address from PC, 1 = from ALUOut
reg_we  out  1  register file write
RegDst  out  2  00 = rt, 01 = rd
DatatoReg  out  2  00 = ALUOut, 01 = MDR
alu_src_a  out  2  00 = PC, 01 = rs, 10 = rt (sll)
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
ExtOp  out  1  0 = zero-extend, 1 = sign-extend
ALUCtrl  out  5  ALUOp_* code from ctrl_encode_def.v
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  out  1  1-cycle pulse on an unsupported opcode/func
err  out  1  sticky memory-timeout trap
state  out  4  current state, for debug

Behaviour:
- States: RST, IF, ID, EXR, EXI, EXA, MRD, MWR, WBR, WBM, BR, JMP, ERR.
- Outputs are a Moore decode of the state register plus opcode/func. In RST and ERR, every output except err and state is 0.
- rst (asynchronous) forces RST, clears err and the wait counter, and aborts any in-flight access with no writes. RST goes to IF on the next clock.
- IF: mem_rd=1, iord=0, alu_src_a=00, alu_src_b=01, ALUCtrl=ADD, pc_src=00. pc_we and ir_we assert only in a cycle with mem_ready=1, and the FSM then moves to ID. Otherwise it stays in IF.
- ID: computes the branch target into ALUOut (src_a=PC, src_b=11, sign-extend). Next state by class:
  - R-type → EXR
  - ori/slti/lui → EXI
  - lw/sw → EXA
  - beq/bne → BR
  - j → JMP
  - anything else → pulse illegal and return to IF.
- EXR → WBR: src_a=01 (rt for sll, ALUCtrl=SLL, src_b=10 with zero-extend), ALUCtrl from func.
- EXI → WBR: src_b=10. ori/lui zero-extend; slti sign-extends.
- WBR: reg_we=1, DatatoReg=00, RegDst=01 for R-type and 00 otherwise. Then IF.
- EXA: rs+sign-extended imm. Then MRD (lw) or MWR (sw).
- MRD and MWR: iord=1 with the strobe held. On mem_ready, MRD goes to WBM and MWR goes to IF.
- WBM: reg_we=1, DatatoReg=01, RegDst=00. Then IF.
- BR: ALUCtrl=EQL for beq, BNE for bne. pc_src=01. pc_we = beq&zero | bne&~zero. Then IF.
- JMP: pc_src=10, pc_we=1. Then IF.
- Latency without waits, in cycles: lw 5; R/I-ALU 4; sw 4; branch 3; j 3.
- Wait counter:
  - 8-bit; clears on entry to IF/MRD/MWR and increments each cycle mem_ready=0.
  - Reaching MEM_TIMEOUT goes to ERR with err=1, no strobes, and no pc/reg write.
  - ERR is held until rst.
  - mem_ready=1 in the same cycle the count hits the limit counts as completion, not a trap.
- mem_ready outside IF/MRD/MWR is ignored.
- Writes to $0 are suppressed by the register file, not by this block.

Optional Feature:
MULTICYCLE_CTRL_PERF_EN:
- Defined: adds outputs cyc_cnt[31:0] and ret_cnt[31:0].
  - cyc_cnt counts every cycle not in RST/ERR.
  - ret_cnt increments on the final cycle of each legal instruction: WBR, WBM, BR, JMP, and MWR with mem_ready.
  - Both are cleared by rst and wrap modulo 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines (ctrl_encode_def.v / instruction_def.v): state encodings, mux select codes for alu_src_a/b, pc_src, iord, and the existing opcode/funct and ALUOp_* constants.
- Sub-module mc_op_decode: combinational, opcode/func → instruction class, ALUCtrl, ExtOp, RegDst, illegal.
- The FSM, wait counter and output decode stay in multicycle_ctrl.

Test Plan:
- addu $3,$1,$2 with mem_ready tied 1 → states IF,ID,EXR,WBR; reg_we=1 only in cycle 4, RegDst=01, ALUCtrl=ALUOp_ADDU.
- lw with mem_ready low for 3 cycles in IF and 2 in MRD → 10 cycles total; ir_we and pc_we one cycle each; DatatoReg=01 in WBM.
- beq with zero=1, then bne with zero=1 → pc_we=1 with pc_src=01 in the first BR; pc_we=0 in the second.
- mem_ready held 0 in MRD with MEM_TIMEOUT=16 → ERR after 16 wait cycles, err=1 and sticky, no reg_we; rst then leads to RST→IF.
- opcode 6'b111111 → illegal pulses for 1 cycle in ID, next state IF, no write strobes.
- rst asserted mid-MWR → mem_wr drops immediately (asynchronously), state=RST; with PERF_EN, cyc_cnt=0 and ret_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// ALU operation codes, datapath mux selects and the decoder bundle.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_IF  = 4'd1,
        S_ID  = 4'd2,
        S_EXR = 4'd3,
        S_EXI = 4'd4,
        S_EXA = 4'd5,
        S_MRD = 4'd6,
        S_MWR = 4'd7,
        S_WBR = 4'd8,
        S_WBM = 4'd9,
        S_BR  = 4'd10,
        S_JMP = 4'd11,
        S_ERR = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        C_ILL = 3'd0,
        C_R   = 3'd1,
        C_I   = 3'd2,
        C_MEM = 3'd3,
        C_BR  = 3'd4,
        C_J   = 3'd5
    } iclass_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_SUB  = 5'd2;
    localparam logic [4:0] ALUOP_ADDU = 5'd3;
    localparam logic [4:0] ALUOP_SUBU = 5'd4;
    localparam logic [4:0] ALUOP_SLT  = 5'd5;
    localparam logic [4:0] ALUOP_SLL  = 5'd6;
    localparam logic [4:0] ALUOP_OR   = 5'd7;
    localparam logic [4:0] ALUOP_LUI  = 5'd8;
    localparam logic [4:0] ALUOP_EQL  = 5'd9;
    localparam logic [4:0] ALUOP_BNE  = 5'd10;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS   = 2'b01;
    localparam logic [1:0] SRCA_RT   = 2'b10;
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;

    localparam logic IORD_PC  = 1'b0;
    localparam logic IORD_ALU = 1'b1;

    typedef struct packed {
        iclass_t    cls;
        logic [4:0] alu;
        logic       ext;
        logic [1:0] rdst;
        logic       sll;
        logic       lw;
        logic       bne;
        logic       illegal;
    } dec_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_op_decode.sv
// Combinational instruction decode: opcode/func to class, ALU op,
// extension mode, destination select and illegal flag.
module mc_op_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            opcode == OP_R: begin
                dec.cls  = C_R;
                dec.rdst = RD_RD;
                unique case (1'b1)
                    func == FN_ADD:  dec.alu = ALUOP_ADD;
                    func == FN_SUB:  dec.alu = ALUOP_SUB;
                    func == FN_ADDU: dec.alu = ALUOP_ADDU;
                    func == FN_SUBU: dec.alu = ALUOP_SUBU;
                    func == FN_SLT:  dec.alu = ALUOP_SLT;
                    func == FN_SLL: begin
                        dec.alu = ALUOP_SLL;
                        dec.sll = 1'b1;
                    end
                    default: dec.cls = C_ILL;
                endcase
            end
            opcode == OP_ORI: begin
                dec.cls = C_I;
                dec.alu = ALUOP_OR;
            end
            opcode == OP_SLTI: begin
                dec.cls = C_I;
                dec.alu = ALUOP_SLT;
                dec.ext = 1'b1;
            end
            opcode == OP_LUI: begin
                dec.cls = C_I;
                dec.alu = ALUOP_LUI;
            end
            opcode == OP_LW: begin
                dec.cls = C_MEM;
                dec.alu = ALUOP_ADD;
                dec.ext = 1'b1;
                dec.lw  = 1'b1;
            end
            opcode == OP_SW: begin
                dec.cls = C_MEM;
                dec.alu = ALUOP_ADD;
                dec.ext = 1'b1;
            end
            opcode == OP_BEQ: begin
                dec.cls = C_BR;
                dec.alu = ALUOP_EQL;
            end
            opcode == OP_BNE: begin
                dec.cls = C_BR;
                dec.alu = ALUOP_BNE;
                dec.bne = 1'b1;
            end
            opcode == OP_J: begin
                dec.cls = C_J;
            end
            default: ;
        endcase
        dec.illegal = (dec.cls == C_ILL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer with memory wait watchdog.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle/retire counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iord,
    output logic        reg_we,
    output logic [1:0]  RegDst,
    output logic [1:0]  DatatoReg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ExtOp,
    output logic [4:0]  ALUCtrl,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic        err,
    output logic [3:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    localparam logic [8:0] LIMIT = 9'(MEM_TIMEOUT);

    state_t     cur;
    state_t     nxt;
    logic [7:0] wcnt;
    logic       in_mem;
    logic       timeout;
    dec_t       dec;

    mc_op_decode u_dec (
        .opcode (opcode),
        .func   (func),
        .dec    (dec)
    );

    assign in_mem  = is_mem_state(cur);
    // ready in the limit cycle wins over the trap
    assign timeout = in_mem && !mem_ready &&
                     (({1'b0, wcnt} + 9'd1) >= LIMIT);

    assign state = cur;
    assign err   = (cur == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_RST;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (nxt != cur) begin
            wcnt <= '0;
        end else if (in_mem && !mem_ready) begin
            wcnt <= wcnt + 8'd1;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_RST: nxt = S_IF;
            S_IF: begin
                if (mem_ready) begin
                    nxt = S_ID;
                end else if (timeout) begin
                    nxt = S_ERR;
                end
            end
            S_ID: begin
                unique case (dec.cls)
                    C_R:     nxt = S_EXR;
                    C_I:     nxt = S_EXI;
                    C_MEM:   nxt = S_EXA;
                    C_BR:    nxt = S_BR;
                    C_J:     nxt = S_JMP;
                    default: nxt = S_IF;
                endcase
            end
            S_EXR: nxt = S_WBR;
            S_EXI: nxt = S_WBR;
            S_EXA: nxt = dec.lw ? S_MRD : S_MWR;
            S_MRD: begin
                if (mem_ready) begin
                    nxt = S_WBM;
                end else if (timeout) begin
                    nxt = S_ERR;
                end
            end
            S_MWR: begin
                if (mem_ready) begin
                    nxt = S_IF;
                end else if (timeout) begin
                    nxt = S_ERR;
                end
            end
            S_WBR: nxt = S_IF;
            S_WBM: nxt = S_IF;
            S_BR:  nxt = S_IF;
            S_JMP: nxt = S_IF;
            S_ERR: nxt = S_ERR;
            default: nxt = S_RST;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = IORD_PC;
        reg_we    = 1'b0;
        RegDst    = RD_RT;
        DatatoReg = WB_ALU;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_RT;
        ExtOp     = 1'b0;
        ALUCtrl   = ALUOP_NOP;
        pc_src    = PCSRC_ALU;
        illegal   = 1'b0;
        unique case (cur)
            S_IF: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_4;
                ALUCtrl   = ALUOP_ADD;
                pc_we     = mem_ready;
                ir_we     = mem_ready;
            end
            S_ID: begin
                alu_src_b = SRCB_BOFF;
                ExtOp     = 1'b1;
                ALUCtrl   = ALUOP_ADD;
                illegal   = dec.illegal;
            end
            S_EXR: begin
                // sll shifts rt by the zero-extended shamt field
                alu_src_a = dec.sll ? SRCA_RT : SRCA_RS;
                alu_src_b = dec.sll ? SRCB_IMM : SRCB_RT;
                ExtOp     = dec.ext;
                ALUCtrl   = dec.alu;
            end
            S_EXI, S_EXA: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                ExtOp     = dec.ext;
                ALUCtrl   = dec.alu;
            end
            S_MRD: begin
                mem_rd = 1'b1;
                iord   = IORD_ALU;
            end
            S_MWR: begin
                mem_wr = 1'b1;
                iord   = IORD_ALU;
            end
            S_WBR: begin
                reg_we = 1'b1;
                RegDst = dec.rdst;
            end
            S_WBM: begin
                reg_we    = 1'b1;
                DatatoReg = WB_MDR;
            end
            S_BR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_RT;
                ALUCtrl   = dec.alu;
                pc_src    = PCSRC_ALUOUT;
                pc_we     = dec.bne ? !zero : zero;
            end
            S_JMP: begin
                pc_src = PCSRC_JUMP;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;

    assign retire = (cur == S_WBR) || (cur == S_WBM) ||
                    (cur == S_BR)  || (cur == S_JMP) ||
                    ((cur == S_MWR) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (cur != S_RST && cur != S_ERR) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (retire) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
